sm83_fetch_decode: RTL

- Opcode fetch and decode front end for the SM83 core.
- Reads instruction bytes from the memory port at the program counter, classifies the opcode and collects any immediate or CB-prefix bytes.
- Presents one decoded `ctl_op_t` with its operands to `control` over a valid/ready handshake.
- `control` drives `op_ready` from its `fetch_cycle` output, so this block is the producer side of the `ctl_op` interface.

---
 rtl/sm83_pkg.sv | 13 +
 rtl/sm83_fetch_decode.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sm83_pkg.sv
// Shared SM83 core types: decoded operation classes passed from fetch/decode to control.
package sm83_pkg;

   typedef enum logic [2:0] {
      CTL_NOP,
      CTL_LD_R8_D8,
      CTL_LD_R16_D16,
      CTL_ALU_R8,
      CTL_CB,
      CTL_ILLEGAL
   } ctl_op_t;

endpackage

// File: rtl/sm83_fetch_decode.sv
// SM83 opcode fetch/decode front end: reads opcode and operand bytes, presents one op to control.
// Optional SM83_CB_PREFIX_EN builds the CB-prefix path (second byte becomes the sub-opcode).
module sm83_fetch_decode
   import sm83_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        pc_load,
   input  logic [15:0] pc_wdata,
   output logic        op_valid,
   input  logic        op_ready,
   output ctl_op_t     ctl_op,
   output logic [7:0]  opcode,
   output logic [15:0] imm,
   output logic [15:0] pc
);

   typedef enum logic [2:0] {
      StFetch,
      StDec,
      StImm0,
      StImm1,
`ifdef SM83_CB_PREFIX_EN
      StCbop,
`endif
      StHold
   } state_t;

   state_t  state;
   ctl_op_t rdata_op;
   logic    rd_req;

   function automatic ctl_op_t decode(input logic [7:0] b);
      ctl_op_t op;
      op = CTL_ILLEGAL;
      if (b == 8'h00) begin
         op = CTL_NOP;
      end else if (b[7:6] == 2'b00 && b[2:0] == 3'b110 && b != 8'h36) begin
         op = CTL_LD_R8_D8;
      end else if (b[7:6] == 2'b00 && b[3:0] == 4'h1) begin
         op = CTL_LD_R16_D16;
      end else if (b[7:6] == 2'b10) begin
         op = CTL_ALU_R8;
`ifdef SM83_CB_PREFIX_EN
      end else if (b == 8'hCB) begin
         op = CTL_CB;
`endif
      end
      return op;
   endfunction

   function automatic logic [1:0] op_len(input ctl_op_t op);
      logic [1:0] len;
      case (op)
         CTL_LD_R8_D8, CTL_CB: len = 2'd2;
         CTL_LD_R16_D16:       len = 2'd3;
         default:              len = 2'd1;
      endcase
      return len;
   endfunction

   always_comb rdata_op = decode(mem_rdata);

   // The DEC-state read depends on the opcode arriving this cycle.
   always_comb begin
      rd_req = 1'b0;
      case (state)
         StFetch: rd_req = 1'b1;
         StDec:   rd_req = (op_len(rdata_op) != 2'd1);
         StImm0:  rd_req = (ctl_op == CTL_LD_R16_D16);
         default: rd_req = 1'b0;
      endcase
   end

   assign mem_rd   = rd_req & rst_n;
   assign mem_addr = pc;
   assign op_valid = (state == StHold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= StFetch;
         pc     <= RESET_PC;
         ctl_op <= CTL_NOP;
         opcode <= 8'h00;
         imm    <= 16'h0000;
      end else if (pc_load) begin
         // Redirect wins everywhere; any read issued this cycle is simply never latched.
         pc    <= pc_wdata;
         state <= StFetch;
      end else begin
         case (state)
            StFetch: begin
               pc    <= pc + 16'd1;
               state <= StDec;
            end
            StDec: begin
               ctl_op <= rdata_op;
               opcode <= mem_rdata;
               if (op_len(rdata_op) == 2'd1) begin
                  state <= StHold;
               end else begin
                  pc <= pc + 16'd1;
`ifdef SM83_CB_PREFIX_EN
                  state <= (rdata_op == CTL_CB) ? StCbop : StImm0;
`else
                  state <= StImm0;
`endif
               end
            end
            StImm0: begin
               imm <= {8'h00, mem_rdata};
               if (ctl_op == CTL_LD_R16_D16) begin
                  pc    <= pc + 16'd1;
                  state <= StImm1;
               end else begin
                  state <= StHold;
               end
            end
            StImm1: begin
               imm[15:8] <= mem_rdata;
               state     <= StHold;
            end
`ifdef SM83_CB_PREFIX_EN
            StCbop: begin
               opcode <= mem_rdata;
               state  <= StHold;
            end
`endif
            StHold: begin
               if (op_ready) state <= StFetch;
            end
            default: state <= StFetch;
         endcase
      end
   end

endmodule
